// File: rtl/hist_pkg.sv
// Shared encodings for the histogram core: status values, error codes and FSM states.
package hist_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_EARLY_LAST   = 2'd1;
  localparam logic [1:0] ERR_MISSING_LAST = 2'd2;
  localparam logic [1:0] ERR_BAD_LEN      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/hist_bin_ram.sv
// Bin storage: simple dual-port RAM, one synchronous read port and one write port.
// Contents are not reset; the core clears them at the start of every frame.
module hist_bin_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hist_axis_core.sv
// AXI-Stream histogram engine: clear bins, accumulate a pixel frame, drain bin counts.
// Define HIST_CUMULATIVE_EN to drain a running sum (CDF) instead of raw counts.
module hist_axis_core
  import hist_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BIN_BITS   = 8,
  parameter int unsigned MAX_PIXELS = 65536,
  parameter int unsigned CNT_W      = $clog2(MAX_PIXELS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  output logic [1:0]       status,
  output logic [1:0]       err_code,
  input  logic [PIX_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [CNT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);

  state_e               state;
  logic [CNT_W-1:0]     len_q, pix_cnt;
  logic [BIN_BITS-1:0]  clr_addr;
  logic                 rmw_v1, rmw_v2;
  logic [BIN_BITS-1:0]  rmw_b1, rmw_b2;
  logic [CNT_W-1:0]     rmw_d2;
  logic [BIN_BITS:0]    rd_ptr;
  logic                 rd_vld;

  logic                 in_hs_c, out_hs_c, load_c, last_pix_c, len_bad_c, ram_we_c;
  logic [BIN_BITS:0]    rd_next_c;
  logic [BIN_BITS-1:0]  in_bin_c, ram_raddr_c, ram_waddr_c;
  logic [CNT_W-1:0]     ram_rdata, ram_wdata_c, rmw_inc_c, beat_c;
  logic                 unused_c;

  assign unused_c = ^{1'b0, s_axis_tdata};

  // Datapath steering; a drain read that is not consumed is simply re-issued
  always_comb begin
    in_bin_c    = s_axis_tdata[PIX_W-1 -: BIN_BITS];
    in_hs_c     = s_axis_tvalid && s_axis_tready;
    out_hs_c    = m_axis_tvalid && m_axis_tready;
    last_pix_c  = (pix_cnt + CNT_W'(1)) == len_q;
    len_bad_c   = (frame_len == '0) || (frame_len > CNT_W'(MAX_PIXELS));
    load_c      = (state == S_DRAIN) && rd_vld && (!m_axis_tvalid || m_axis_tready);
    rd_next_c   = load_c ? rd_ptr + (BIN_BITS+1)'(1) : rd_ptr;
    rmw_inc_c   = ((rmw_v2 && (rmw_b2 == rmw_b1)) ? rmw_d2 : ram_rdata) + CNT_W'(1);
    ram_we_c    = (state == S_CLEAR) || rmw_v1;
    ram_waddr_c = (state == S_CLEAR) ? clr_addr : rmw_b1;
    ram_wdata_c = (state == S_CLEAR) ? '0 : rmw_inc_c;
    ram_raddr_c = (state == S_DRAIN) ? rd_next_c[BIN_BITS-1:0] : in_bin_c;
  end

`ifdef HIST_CUMULATIVE_EN
  logic [CNT_W-1:0] acc;

  // acc tracks the last accepted cumulative beat
  assign beat_c = (out_hs_c ? m_axis_tdata : acc) + ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   acc <= '0;
    else if (state == S_FLUSH) acc <= '0;
    else if (out_hs_c)         acc <= m_axis_tdata;
  end
`else
  assign beat_c = ram_rdata;
`endif

  hist_bin_ram #(
    .ADDR_W (BIN_BITS),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata)
  );

  // RMW pipe: stage 1 waits on the RAM read, stage 2 remembers the last write for forwarding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_v1 <= 1'b0;
      rmw_v2 <= 1'b0;
      rmw_b1 <= '0;
      rmw_b2 <= '0;
      rmw_d2 <= '0;
    end else begin
      rmw_v1 <= in_hs_c;
      rmw_b1 <= in_bin_c;
      rmw_v2 <= rmw_v1;
      rmw_b2 <= rmw_b1;
      rmw_d2 <= rmw_inc_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      status        <= ST_IDLE;
      err_code      <= ERR_NONE;
      len_q         <= '0;
      pix_cnt       <= '0;
      clr_addr      <= '0;
      rd_ptr        <= '0;
      rd_vld        <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            len_q    <= frame_len;
            err_code <= ERR_NONE;
            pix_cnt  <= '0;
            clr_addr <= '0;
            if (len_bad_c) begin
              state    <= S_ERROR;
              status   <= ST_ERROR;
              err_code <= ERR_BAD_LEN;
            end else begin
              state  <= S_CLEAR;
              status <= ST_BUSY;
            end
          end
        end
        S_CLEAR: begin
          clr_addr <= clr_addr + BIN_BITS'(1);
          if (&clr_addr) begin
            state         <= S_ACCUM;
            s_axis_tready <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (in_hs_c) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
            if (s_axis_tlast && last_pix_c) begin
              state         <= S_FLUSH;
              s_axis_tready <= 1'b0;
            end else if (s_axis_tlast || last_pix_c) begin
              state         <= S_ERROR;
              status        <= ST_ERROR;
              err_code      <= s_axis_tlast ? ERR_EARLY_LAST : ERR_MISSING_LAST;
              s_axis_tready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          state  <= S_DRAIN;
          rd_ptr <= '0;
          rd_vld <= 1'b0;
        end
        S_DRAIN: begin
          rd_ptr <= rd_next_c;
          rd_vld <= !rd_next_c[BIN_BITS];
          if (load_c) begin
            m_axis_tdata  <= beat_c;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= &rd_ptr[BIN_BITS-1:0];
          end else if (out_hs_c) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
          if (out_hs_c && m_axis_tlast) begin
            state         <= S_DONE;
            status        <= ST_DONE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          status <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
